// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and defaults for the LED pattern sequencer
package led_pkg;

  localparam int LED_W_DEF = 8;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    SHIFT  = 2'd1,
    BLINK  = 2'd2,
    COUNT  = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } led_state_t;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running divider producing one advance strobe per TICK_DIV enabled cycles
module led_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Strobe is combinational so the parent can register the advance on the wrap edge
  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - configuration handshake, mode latches and LED update sequencer
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int LED_W    = LED_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [LED_W-1:0] cfg_pattern,
  input  logic             run_en,
  output logic [LED_W-1:0] led_out,
  output logic             tick,
  output logic             busy
);

  led_state_t       state, state_nxt;
  led_mode_t        mode_q, mode_nxt;
  logic [LED_W-1:0] pattern_q, pattern_nxt;
  logic [LED_W-1:0] led_nxt;
  logic             phase_q, phase_nxt;
  logic             tick_nxt, ready_nxt;
  logic             hs, pre_tick;

  assign hs   = cfg_valid && cfg_ready;
  assign busy = (state != IDLE);

  led_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == LOAD),
    .en   ((state == RUN) && run_en),
    .tick (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= STATIC;
      pattern_q <= '0;
      phase_q   <= 1'b0;
      led_out   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      pattern_q <= pattern_nxt;
      phase_q   <= phase_nxt;
      led_out   <= led_nxt;
      tick      <= tick_nxt;
      cfg_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode_q;
    pattern_nxt = pattern_q;
    phase_nxt   = phase_q;
    led_nxt     = led_out;
    tick_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt   = LOAD;
          mode_nxt    = led_mode_t'(cfg_mode);
          pattern_nxt = cfg_pattern;
        end
      end
      LOAD: begin
        state_nxt = RUN;
        led_nxt   = pattern_q;
        phase_nxt = 1'b1;
      end
      RUN: begin
        // A new configuration takes priority; a coincident advance is dropped
        if (hs) begin
          state_nxt   = LOAD;
          mode_nxt    = led_mode_t'(cfg_mode);
          pattern_nxt = cfg_pattern;
        end else if (pre_tick) begin
          tick_nxt = 1'b1;
          case (mode_q)
            SHIFT:   led_nxt = {led_out[LED_W-2:0], led_out[LED_W-1]};
            BLINK: begin
              phase_nxt = ~phase_q;
              led_nxt   = phase_q ? '0 : pattern_q;
            end
            COUNT:   led_nxt = led_out + 1'b1;
            default: led_nxt = led_out;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt != LOAD);
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl against a cycle-count reference model
module tb_led_pattern_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_pattern = 8'h00;
  logic       run_en = 1'b0;
  logic [7:0] led_out;
  logic       tick;
  logic       busy;

  led_pattern_ctrl #(.TICK_DIV(TD), .LED_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_pattern (cfg_pattern),
    .run_en      (run_en),
    .led_out     (led_out),
    .tick        (tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  led;
    logic        tick;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  tick_log[$];
  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: configuration accepted, one load cycle, then an advance every TD enabled run cycles
  bit          m_ready, m_busy, m_loading, m_phase, m_tick;
  int          m_mode, m_runs;
  int          m_pat, m_led;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].edge_no == edge_n) begin
      mon_e = q.pop_front();
      chk("led_out", {24'd0, led_out}, {24'd0, mon_e.led});
      chk("tick", {31'd0, tick}, {31'd0, mon_e.tick});
      chk("busy", {31'd0, busy}, {31'd0, mon_e.busy});
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, mon_e.ready});
      if (tick === 1'b1) tick_log.push_back(led_out);
    end
  end

  task automatic model_reset();
    m_ready = 0; m_busy = 0; m_loading = 0; m_phase = 0; m_tick = 0;
    m_mode = 0; m_runs = 0; m_pat = 0; m_led = 0;
  endtask

  task automatic cycle(input bit v, input bit [1:0] md, input bit [7:0] pt, input bit en);
    exp_t e;
    bit hs;
    cfg_valid = v; cfg_mode = md; cfg_pattern = pt; run_en = en;
    hs = v && m_ready;
    m_tick = 0;
    if (m_loading) begin
      m_led = m_pat; m_phase = 1; m_runs = 0; m_loading = 0; m_ready = 1;
    end else if (hs) begin
      m_mode = md; m_pat = pt; m_loading = 1; m_ready = 0; m_busy = 1;
    end else if (m_busy && en) begin
      m_runs++;
      if (m_runs % TD == 0) begin
        m_tick = 1;
        case (m_mode)
          1: m_led = ((m_led << 1) | (m_led >> 7)) % 256;
          2: begin m_phase = !m_phase; m_led = m_phase ? m_pat : 0; end
          3: m_led = (m_led + 1) % 256;
          default: ;
        endcase
      end
    end else if (!m_busy) begin
      m_ready = 1;
    end
    e.edge_no = edge_n + 1;
    e.led = m_led[7:0]; e.tick = m_tick; e.busy = m_busy; e.ready = m_ready;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  function automatic bit advance_next();
    return m_busy && !m_loading && ((m_runs + 1) % TD == 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Test 1: reset state and ready one edge after release
    #12;
    chk("rst_led", {24'd0, led_out}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(0, 0, 8'h00, 1);
    chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
    cycle(0, 0, 8'h00, 1);

    // Test 2: SHIFT 0x81
    settle(); tick_log.delete();
    cycle(1, 2'd1, 8'h81, 1);
    cycle(0, 0, 8'h00, 1);
    chk("shift_e1", {24'd0, led_out}, 32'h81);
    for (int i = 0; i < 3 * TD; i++) cycle(0, 0, 8'h00, 1);
    settle();
    chk("shift_ticks", tick_log.size(), 3);
    if (tick_log.size() == 3) begin
      chk("shift_t1", {24'd0, tick_log[0]}, 32'h03);
      chk("shift_t2", {24'd0, tick_log[1]}, 32'h06);
      chk("shift_t3", {24'd0, tick_log[2]}, 32'h0C);
    end

    // Test 3: COUNT wrap from 0xFE
    tick_log.delete();
    cycle(1, 2'd3, 8'hFE, 1);
    cycle(0, 0, 8'h00, 1);
    chk("count_e1", {24'd0, led_out}, 32'hFE);
    for (int i = 0; i < 3 * TD; i++) cycle(0, 0, 8'h00, 1);
    settle();
    chk("count_ticks", tick_log.size(), 3);
    if (tick_log.size() == 3) begin
      chk("count_t1", {24'd0, tick_log[0]}, 32'hFF);
      chk("count_t2", {24'd0, tick_log[1]}, 32'h00);
      chk("count_t3", {24'd0, tick_log[2]}, 32'h01);
    end

    // Test 4: BLINK with a freeze after the first tick
    cycle(1, 2'd2, 8'hA5, 1);
    cycle(0, 0, 8'h00, 1);
    chk("blink_e1", {24'd0, led_out}, 32'hA5);
    for (int i = 0; i < 2 * TD && !m_tick; i++) cycle(0, 0, 8'h00, 1);
    chk("blink_off", {24'd0, led_out}, 32'h00);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 0);
    chk("blink_frozen", {24'd0, led_out}, 32'h00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
    chk("blink_on", {24'd0, led_out}, 32'hA5);
    chk("blink_tick", {31'd0, tick}, 32'd1);

    // Test 5: handshake collides with a COUNT advance
    cycle(1, 2'd3, 8'h10, 1);
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 2 * TD && !advance_next(); i++) cycle(0, 0, 8'h00, 1);
    cycle(1, 2'd0, 8'h3C, 1);
    chk("collide_led", {24'd0, led_out}, 32'h10);
    chk("collide_tick", {31'd0, tick}, 32'd0);
    chk("collide_ready", {31'd0, cfg_ready}, 32'd0);
    cycle(1, 2'd0, 8'h3C, 1);
    chk("static_e1", {24'd0, led_out}, 32'h3C);
    chk("static_ready", {31'd0, cfg_ready}, 32'd1);
    cycle(0, 0, 8'h00, 1);
    settle(); tick_log.delete();
    for (int i = 0; i < 3 * TD; i++) cycle(0, 0, 8'h00, 1);
    settle();
    chk("static_ticks", tick_log.size(), 3);
    foreach (tick_log[i]) chk("static_led", {24'd0, tick_log[i]}, 32'h3C);

    // Test 6: asynchronous reset mid-count
    cycle(1, 2'd3, 8'h20, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 8'h00, 1);
    settle();
    q.delete();
    rst = 1'b1;
    #1;
    chk("arst_led", {24'd0, led_out}, 32'h00);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, cfg_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * TD; i++) cycle(0, 0, 8'h00, 1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_led", {24'd0, led_out}, 32'h00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
    end
    settle();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
